bus_target_8227: RTL and testbench
==================================

Name: bus_target_8227

Overview:
Memory-mapped responder on the outel8227 CPU bus. It answers CPU reads and writes in a 16-byte window. It inserts read wait states by driving ready low, and holds 12 scratch bytes plus a cycle-counting timer that raises the active-low interrupt or non-maskable interrupt pins. It sits beside the CPU at the top level: the CPU's address and data outputs feed it, and its data output feeds the CPU data input mux.

Parameters:
BASE_ADDR, 16'hD000, window base; bits [3:0] ignored; hit when address[15:4]==BASE_ADDR[15:4]
WAIT_CYCLES, 1, bus-strobe periods of stall per read hit; legal 0..15
RESET_CTRL, 8'h00, CTRL register value after reset

Ports:
clk  in  1  system clock
nrst  in  1  asynchronous active-low reset
busStrobe  in  1  one-clk pulse marking the end of a CPU bus cycle (functional clock)
address  in  16  CPU address bus {high,low}
readNotWrite  in  1  1=read, 0=write
dataFromCpu  in  8  CPU write data
dataToCpu  out  8  read data to CPU
dataDrive  out  1  1 = this block owns the CPU data input this cycle
ready  out  1  to CPU ready; 0 stalls read cycles
interruptRequest  out  1  active-low IRQ, level
nonMaskableInterrupt  out  1  active-low NMI, level (the CPU edge-detects it)

Behaviour:
- Reset (async, nrst=0) values:
  - dataToCpu=0, dataDrive=0, ready=1, interruptRequest=1, nonMaskableInterrupt=1.
  - Scratch=0, TLO=THI=0, counter=0, CTRL=RESET_CTRL, STATUS=0, FSM=IDLE.
- Register map (offset = address[3:0]):
  - 0x0-0xB: scratch RAM, read/write.
  - 0xC: TLO reload; write only sets the reload value.
  - 0xD: THI reload; write also loads counter <= {new THI, TLO}.
  - 0xE: CTRL. b0 timer enable, b1 int enable, b2 route to NMI, b3 auto-reload; b7:4 read 0.
  - 0xF: STATUS. b0 expired flag; write 1 to clear.
- Reads of 0xC/0xD return the live counter low/high bytes, not the reload values.
- Read path (1 clk latency):
  - Each clk, dataDrive <= hit & readNotWrite.
  - dataToCpu <= selected register on a hit, else 8'h00.
- Writes: committed only on a clk where busStrobe=1, hit=1, readNotWrite=0. Writes never stall.
- Stall FSM (IDLE, STALL, RELEASE):
  - IDLE: read hit seen and WAIT_CYCLES>0 → ready<=0, waitCnt<=WAIT_CYCLES, go STALL. Stall starts 1 clk after the address is valid, before the strobe.
  - STALL: each busStrobe decrements waitCnt. When waitCnt==1 at a strobe, ready<=1 and go RELEASE.
  - RELEASE: the next busStrobe completes the read → IDLE. A new hit read cannot restart a stall until IDLE is reached.
  - Address leaves the window or readNotWrite drops while in STALL/RELEASE → ready<=1, go IDLE (abort).
  - WAIT_CYCLES==0: FSM stays IDLE and ready stays 1.
- Timer (counts busStrobe pulses, including strobes during a stall):
  - At a strobe with enable=1 and counter!=0: counter decrements.
  - At a strobe with enable=1 and counter==0: flag<=1. If auto-reload, counter<={THI,TLO}; else CTRL.b0<=0.
  - Period = reload+1 strobes.
- Simultaneous events:
  - Expiry on the same strobe as a W1C write to STATUS: set wins, flag=1.
  - Write to THI on an expiry strobe: the write-load wins over the reload.
  - CPU write to CTRL on the same strobe as an auto-disable: the CPU write wins.
- Interrupt outputs (registered from state, 1 clk after a flag or CTRL change):
  - interruptRequest = ~(flag & b1 & ~b2).
  - nonMaskableInterrupt = ~(flag & b1 & b2).
- Reset mid-stall: ready returns to 1 immediately (asynchronous).

Decomposition:
- Package outel8227_bus_pkg holds:
  - register offset localparams (SCRATCH_LAST, TLO, THI, CTRL, STATUS);
  - CTRL bit indices;
  - the stall state enum.
- One sub-module, target_timer, holds the counter, reload registers, expiry flag and W1C/set priority. The top keeps decode, scratch, the FSM and the interrupt outputs.

Test Plan:
- Reset release, no bus activity → ready=1, both interrupt pins=1, dataDrive=0.
- Write 0x5A to 0xD003, then read 0xD003 with WAIT_CYCLES=1:
  - ready low 1 clk after the address;
  - ready high after 1 strobe;
  - dataToCpu=0x5A, dataDrive=1 at the completing strobe.
- Read 0xC003 (miss) → dataDrive=0, dataToCpu=0x00, ready never drops.
- TLO=0x03, THI=0x00, CTRL=0x03 → interruptRequest low 1 clk after the 4th strobe; CTRL.b0 reads 0. Write 0x01 to STATUS → interruptRequest high.
- CTRL=0x0F, reload=2 → nonMaskableInterrupt low; flag re-sets every 3 strobes. A W1C on an expiry strobe leaves flag=1.
- Assert nrst low mid-STALL → ready=1 asynchronously, scratch cleared, FSM=IDLE.

Source files
------------

// File: rtl/outel8227_bus_pkg.sv
// ---------------------------------------------------------------------------
// outel8227_bus_pkg
// Shared definitions for the outel8227 bus target: register offsets inside
// the 16-byte window, CTRL/STATUS bit positions and the read-stall FSM
// state type.
// ---------------------------------------------------------------------------
package outel8227_bus_pkg;

    // Register offsets (address[3:0]); 0x0..SCRATCH_LAST are scratch bytes
    localparam logic [3:0] SCRATCH_LAST = 4'hB;
    localparam logic [3:0] TLO          = 4'hC;
    localparam logic [3:0] THI          = 4'hD;
    localparam logic [3:0] CTRL         = 4'hE;
    localparam logic [3:0] STATUS       = 4'hF;

    localparam int SCRATCH_BYTES = 12;

    // CTRL bit indices
    localparam int CTRL_EN  = 0;  // timer enable
    localparam int CTRL_IE  = 1;  // interrupt enable
    localparam int CTRL_NMI = 2;  // route interrupt to NMI instead of IRQ
    localparam int CTRL_AR  = 3;  // auto-reload on expiry

    // STATUS bit indices
    localparam int STATUS_EXP = 0;  // expired flag, write 1 to clear

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STALL   = 2'd1,
        ST_RELEASE = 2'd2
    } stall_state_e;

endpackage

// File: rtl/target_timer.sv
// ---------------------------------------------------------------------------
// target_timer
// Bus-strobe counting timer of the outel8227 bus target. Holds the TLO/THI
// reload bytes, the 16-bit down counter and the expired flag.
//
// Ports:
//   clk_i, nrst_i    clock, asynchronous active-low reset
//   strobe_i         bus strobe (one tick per CPU bus cycle)
//   enable_i         CTRL timer enable
//   auto_reload_i    CTRL auto-reload
//   wr_tlo_i         strobe-qualified write to TLO
//   wr_thi_i         strobe-qualified write to THI (also loads the counter)
//   wr_status_i      strobe-qualified write to STATUS (W1C)
//   wdata_i          CPU write data
//   count_o          live counter value
//   flag_o           expired flag
//   auto_disable_o   expiry without auto-reload: request to clear CTRL enable
// ---------------------------------------------------------------------------
module target_timer
    import outel8227_bus_pkg::*;
(
    input  logic        clk_i,
    input  logic        nrst_i,
    input  logic        strobe_i,
    input  logic        enable_i,
    input  logic        auto_reload_i,
    input  logic        wr_tlo_i,
    input  logic        wr_thi_i,
    input  logic        wr_status_i,
    input  logic [7:0]  wdata_i,
    output logic [15:0] count_o,
    output logic        flag_o,
    output logic        auto_disable_o
);

    logic [7:0]  tlo_q, tlo_d;
    logic [7:0]  thi_q, thi_d;
    logic [15:0] cnt_q, cnt_d;
    logic        flag_q, flag_d;
    logic        tick;
    logic        expire;

    assign tick   = strobe_i & enable_i;
    assign expire = tick & (cnt_q == 16'd0);

    always_comb begin
        tlo_d  = tlo_q;
        thi_d  = thi_q;
        cnt_d  = cnt_q;
        flag_d = flag_q;

        if (tick) begin
            if (cnt_q != 16'd0) begin
                cnt_d = cnt_q - 16'd1;
            end else if (auto_reload_i) begin
                cnt_d = {thi_q, tlo_q};
            end
        end

        if (wr_tlo_i) begin
            tlo_d = wdata_i;
        end
        // A THI write loads the counter and overrides any reload this strobe
        if (wr_thi_i) begin
            thi_d = wdata_i;
            cnt_d = {wdata_i, tlo_q};
        end

        // Expiry set takes priority over a simultaneous write-1-to-clear
        if (wr_status_i && wdata_i[STATUS_EXP]) begin
            flag_d = 1'b0;
        end
        if (expire) begin
            flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            tlo_q  <= 8'h00;
            thi_q  <= 8'h00;
            cnt_q  <= 16'h0000;
            flag_q <= 1'b0;
        end else begin
            tlo_q  <= tlo_d;
            thi_q  <= thi_d;
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
        end
    end

    assign count_o        = cnt_q;
    assign flag_o         = flag_q;
    assign auto_disable_o = expire & ~auto_reload_i;

endmodule

// File: rtl/bus_target_8227.sv
// ---------------------------------------------------------------------------
// bus_target_8227
// Memory-mapped responder on the outel8227 CPU bus, 16-byte window at
// BASE_ADDR. 12 scratch bytes, a strobe-counting timer (TLO/THI/CTRL/STATUS)
// and a read-stall FSM that holds ready low for WAIT_CYCLES bus strobes.
//
// Ports:
//   clk, nrst              clock, asynchronous active-low reset
//   busStrobe              one-clk pulse at the end of each CPU bus cycle
//   address                CPU address
//   readNotWrite           1 = read, 0 = write
//   dataFromCpu            CPU write data
//   dataToCpu              registered read data (0 when not hit)
//   dataDrive              this block owns the CPU data input
//   ready                  0 stalls the current read
//   interruptRequest       active-low IRQ level
//   nonMaskableInterrupt   active-low NMI level
// ---------------------------------------------------------------------------
module bus_target_8227
    import outel8227_bus_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = 16'hD000,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [7:0]  RESET_CTRL  = 8'h00
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        busStrobe,
    input  logic [15:0] address,
    input  logic        readNotWrite,
    input  logic [7:0]  dataFromCpu,
    output logic [7:0]  dataToCpu,
    output logic        dataDrive,
    output logic        ready,
    output logic        interruptRequest,
    output logic        nonMaskableInterrupt
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
    localparam bit         STALL_EN  = (WAIT_CYCLES != 0);

    logic        hit;
    logic        rd_hit;
    logic        wr_en;
    logic [3:0]  off;
    logic [7:0]  rd_data;

    logic [7:0]  scratch_q [SCRATCH_BYTES];
    logic [3:0]  ctrl_q, ctrl_d;
    logic [7:0]  dout_q;
    logic        drive_q;
    logic        irq_q, nmi_q;

    stall_state_e state_q, state_d;
    logic         ready_q, ready_d;
    logic [3:0]   wcnt_q, wcnt_d;

    logic [15:0] count;
    logic        flag;
    logic        auto_disable;

    assign off    = address[3:0];
    assign hit    = (address[15:4] == BASE_ADDR[15:4]);
    assign rd_hit = hit & readNotWrite;
    assign wr_en  = busStrobe & hit & ~readNotWrite;

    target_timer u_timer (
        .clk_i          (clk),
        .nrst_i         (nrst),
        .strobe_i       (busStrobe),
        .enable_i       (ctrl_q[CTRL_EN]),
        .auto_reload_i  (ctrl_q[CTRL_AR]),
        .wr_tlo_i       (wr_en && (off == TLO)),
        .wr_thi_i       (wr_en && (off == THI)),
        .wr_status_i    (wr_en && (off == STATUS)),
        .wdata_i        (dataFromCpu),
        .count_o        (count),
        .flag_o         (flag),
        .auto_disable_o (auto_disable)
    );

    // Read mux: TLO/THI offsets return the live counter, not the reload bytes
    always_comb begin
        rd_data = 8'h00;
        if (off <= SCRATCH_LAST) begin
            rd_data = scratch_q[off];
        end else begin
            case (off)
                TLO:     rd_data = count[7:0];
                THI:     rd_data = count[15:8];
                CTRL:    rd_data = {4'h0, ctrl_q};
                STATUS:  rd_data = {7'h00, flag};
                default: rd_data = 8'h00;
            endcase
        end
    end

    // CPU write to CTRL overrides the timer's auto-disable on the same strobe
    always_comb begin
        ctrl_d = ctrl_q;
        if (auto_disable) begin
            ctrl_d[CTRL_EN] = 1'b0;
        end
        if (wr_en && (off == CTRL)) begin
            ctrl_d = dataFromCpu[3:0];
        end
    end

    // Stall FSM: ready drops on the first clk a hit read is seen, then the
    // read is held for WAIT_CYCLES strobes; leaving the read aborts the stall
    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (STALL_EN && rd_hit) begin
                    ready_d = 1'b0;
                    wcnt_d  = WAIT_INIT;
                    state_d = ST_STALL;
                end
            end
            ST_STALL: begin
                if (!rd_hit) begin
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (busStrobe) begin
                    wcnt_d = wcnt_q - 4'd1;
                    if (wcnt_q == 4'd1) begin
                        ready_d = 1'b1;
                        state_d = ST_RELEASE;
                    end
                end
            end
            ST_RELEASE: begin
                if (!rd_hit) begin
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (busStrobe) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            wcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < SCRATCH_BYTES; i++) begin
                scratch_q[i] <= 8'h00;
            end
        end else if (wr_en && (off <= SCRATCH_LAST)) begin
            scratch_q[off] <= dataFromCpu;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ctrl_q  <= RESET_CTRL[3:0];
            dout_q  <= 8'h00;
            drive_q <= 1'b0;
            irq_q   <= 1'b1;
            nmi_q   <= 1'b1;
        end else begin
            ctrl_q  <= ctrl_d;
            dout_q  <= hit ? rd_data : 8'h00;
            drive_q <= rd_hit;
            irq_q   <= ~(flag & ctrl_q[CTRL_IE] & ~ctrl_q[CTRL_NMI]);
            nmi_q   <= ~(flag & ctrl_q[CTRL_IE] &  ctrl_q[CTRL_NMI]);
        end
    end

    assign dataToCpu            = dout_q;
    assign dataDrive            = drive_q;
    assign ready                = ready_q;
    assign interruptRequest     = irq_q;
    assign nonMaskableInterrupt = nmi_q;

endmodule

// File: tb/tb_bus_target_8227.sv
module tb_bus_target_8227;

    localparam int WAIT = 1;

    logic        clk = 1'b0;
    logic        nrst;
    logic        busStrobe;
    logic [15:0] address;
    logic        readNotWrite;
    logic [7:0]  dataFromCpu;
    logic [7:0]  dataToCpu;
    logic        dataDrive;
    logic        ready;
    logic        interruptRequest;
    logic        nonMaskableInterrupt;

    always #5 clk = ~clk;

    bus_target_8227 #(
        .BASE_ADDR   (16'hD000),
        .WAIT_CYCLES (WAIT),
        .RESET_CTRL  (8'h00)
    ) dut (
        .clk                  (clk),
        .nrst                 (nrst),
        .busStrobe            (busStrobe),
        .address              (address),
        .readNotWrite         (readNotWrite),
        .dataFromCpu          (dataFromCpu),
        .dataToCpu            (dataToCpu),
        .dataDrive            (dataDrive),
        .ready                (ready),
        .interruptRequest     (interruptRequest),
        .nonMaskableInterrupt (nonMaskableInterrupt)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Scoreboard entries: {expected dataDrive, expected dataToCpu}
    logic [8:0] exp_q [$];

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle2();
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic idle_strobe();
        cyc();
        busStrobe = 1'b1;
        cyc();
        busStrobe = 1'b0;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        cyc();
        address      = a;
        readNotWrite = 1'b0;
        dataFromCpu  = d;
        cyc();
        busStrobe = 1'b1;
        @(negedge clk);
        chk_eq("wr_ready", 32'(ready), 32'd1);
        cyc();
        busStrobe    = 1'b0;
        address      = 16'h0000;
        readNotWrite = 1'b1;
    endtask

    task automatic bus_read(input string tag, input logic [15:0] a, input logic [7:0] exp_d);
        logic       hit;
        logic [8:0] e;
        int         stalls;
        bit         done;
        hit = (a[15:4] == 12'hD00);
        exp_q.push_back({hit, hit ? exp_d : 8'h00});
        cyc();
        address      = a;
        readNotWrite = 1'b1;
        busStrobe    = 1'b0;
        @(negedge clk);
        chk_eq({tag, "_rdy_addr"}, 32'(ready), 32'd1);
        @(negedge clk);
        chk_eq({tag, "_rdy_next"}, 32'(ready), (hit && WAIT > 0) ? 32'd0 : 32'd1);
        stalls = 0;
        done   = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            cyc();
            busStrobe = 1'b1;
            @(negedge clk);
            if (ready) begin
                e = exp_q.pop_front();
                chk_eq({tag, "_data"},  32'(dataToCpu), 32'(e[7:0]));
                chk_eq({tag, "_drive"}, 32'(dataDrive), 32'(e[8]));
                done = 1'b1;
            end else begin
                stalls++;
            end
            cyc();
            busStrobe = 1'b0;
        end
        chk_eq({tag, "_done"}, 32'(done), 32'd1);
        chk_eq({tag, "_stalls"}, 32'(stalls), hit ? 32'(WAIT) : 32'd0);
        address = 16'h0000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst         = 1'b0;
        busStrobe    = 1'b0;
        address      = 16'h0000;
        readNotWrite = 1'b1;
        dataFromCpu  = 8'h00;
        repeat (3) @(posedge clk);
        #1 nrst = 1'b1;
        settle2();
        chk_eq("rst_ready", 32'(ready), 32'd1);
        chk_eq("rst_irq",   32'(interruptRequest), 32'd1);
        chk_eq("rst_nmi",   32'(nonMaskableInterrupt), 32'd1);
        chk_eq("rst_drive", 32'(dataDrive), 32'd0);
        chk_eq("rst_data",  32'(dataToCpu), 32'd0);

        // Scratch and miss
        bus_write(16'hD003, 8'h5A);
        bus_read("scr3", 16'hD003, 8'h5A);
        bus_write(16'hD000, 8'hA5);
        bus_write(16'hD00B, 8'h3C);
        bus_read("scr0", 16'hD000, 8'hA5);
        bus_read("scr11", 16'hD00B, 8'h3C);
        bus_read("miss", 16'hC003, 8'h00);
        bus_write(16'hD00E, 8'hF0);
        bus_read("ctrl_hi", 16'hD00E, 8'h00);

        // THI write loads the live counter
        bus_write(16'hD00C, 8'h34);
        bus_write(16'hD00D, 8'h12);
        bus_read("cnt_lo", 16'hD00C, 8'h34);
        bus_read("cnt_hi", 16'hD00D, 8'h12);

        // One-shot IRQ: counter 3, expiry on the 4th strobe
        bus_write(16'hD00C, 8'h03);
        bus_write(16'hD00D, 8'h00);
        bus_write(16'hD00E, 8'h03);
        repeat (3) idle_strobe();
        settle2();
        chk_eq("irq_pre", 32'(interruptRequest), 32'd1);
        idle_strobe();
        @(negedge clk);
        chk_eq("irq_lat", 32'(interruptRequest), 32'd1);
        @(negedge clk);
        chk_eq("irq_low", 32'(interruptRequest), 32'd0);
        chk_eq("irq_nmi", 32'(nonMaskableInterrupt), 32'd1);
        bus_read("ctrl_dis", 16'hD00E, 8'h02);
        bus_read("status1", 16'hD00F, 8'h01);
        bus_write(16'hD00F, 8'h01);
        settle2();
        chk_eq("irq_clr", 32'(interruptRequest), 32'd1);

        // Auto-reload NMI, reload 2 -> period 3 strobes
        bus_write(16'hD00C, 8'h02);
        bus_write(16'hD00D, 8'h00);
        bus_write(16'hD00E, 8'h0F);
        repeat (2) idle_strobe();
        settle2();
        chk_eq("nmi_pre", 32'(nonMaskableInterrupt), 32'd1);
        idle_strobe();
        settle2();
        chk_eq("nmi_low", 32'(nonMaskableInterrupt), 32'd0);
        chk_eq("nmi_irq", 32'(interruptRequest), 32'd1);
        bus_write(16'hD00F, 8'h01);
        settle2();
        chk_eq("nmi_clr", 32'(nonMaskableInterrupt), 32'd1);
        idle_strobe();
        settle2();
        chk_eq("nmi_mid", 32'(nonMaskableInterrupt), 32'd1);
        idle_strobe();
        settle2();
        chk_eq("nmi_period", 32'(nonMaskableInterrupt), 32'd0);
        bus_write(16'hD00F, 8'h01);
        settle2();
        chk_eq("nmi_clr2", 32'(nonMaskableInterrupt), 32'd1);
        idle_strobe();
        bus_write(16'hD00F, 8'h01);  // lands on the expiry strobe
        settle2();
        chk_eq("w1c_vs_set", 32'(nonMaskableInterrupt), 32'd0);
        bus_read("status2", 16'hD00F, 8'h01);
        bus_write(16'hD00E, 8'h00);

        // Reset in the middle of a stall
        cyc();
        address      = 16'hD003;
        readNotWrite = 1'b1;
        settle2();
        chk_eq("stall_pre_rst", 32'(ready), 32'd0);
        #2 nrst = 1'b0;
        #1;
        chk_eq("rst_async_ready", 32'(ready), 32'd1);
        chk_eq("rst_async_nmi", 32'(nonMaskableInterrupt), 32'd1);
        address = 16'h0000;
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;
        settle2();
        chk_eq("post_rst_ready", 32'(ready), 32'd1);
        bus_read("scr_rst", 16'hD003, 8'h00);

        chk_eq("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
